// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings, FSM states
// and bounce direction constants.
package led_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_STATUS = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // CHASE and BOUNCE both start from a single lit LED at bit 0.
    function automatic logic mode_is_walker(mode_e m);
        return (m == MODE_CHASE) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/drive bundle of the LED pattern generator. Brightness exists only
// when LED_PWM_EN is defined.
interface led_pattern_gen_if #(
    parameter int N_LED    = 6,
    parameter int PWM_BITS = 4
);
    logic [1:0]       Mode;
    logic [N_LED-1:0] Status;
    logic             Freeze;
`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] Brightness;
`endif
    logic [N_LED-1:0] LED;
    logic             Tick_Out;

`ifdef LED_PWM_EN
    modport master (output Mode, Status, Freeze, Brightness, input LED, Tick_Out);
    modport slave  (input Mode, Status, Freeze, Brightness, output LED, Tick_Out);
`else
    modport master (output Mode, Status, Freeze, input LED, Tick_Out);
    modport slave  (input Mode, Status, Freeze, output LED, Tick_Out);
`endif

endinterface

// File: rtl/led_tick_gen.sv
// Pattern-step timebase: counts 0..TICK_DIV-1 and flags the terminal count.
// Clr restarts the count and suppresses the flag; Hold freezes both.
module led_tick_gen #(
    parameter int TICK_DIV = 40000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clr,
    input  logic Hold,
    output logic Tick
);

    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (Clr) begin
            cnt_d = '0;
        end else if (!Hold) begin
            cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = at_max & ~Hold & ~Clr;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: CHASE / BOUNCE / BLINK / STATUS patterns stepped by a
// divided tick. Optional PWM dimming when LED_PWM_EN is defined.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int N_LED    = 6,
    parameter int TICK_DIV = 40000000,
    parameter int PWM_BITS = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    led_pattern_gen_if.slave   bus
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d, mode_in;
    logic [N_LED-1:0] pattern_q, pattern_d, init_pattern, rot_left;
    logic             dir_q, dir_d;
    logic             tick_out_q, tick_out_d;
    logic             tick, load, mode_change;

    assign mode_in     = mode_e'(bus.Mode);
    assign mode_change = (mode_in != mode_q);
    assign mode_d      = mode_in;
    assign tick_out_d  = tick;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .Clr  (load),
        .Hold (bus.Freeze),
        .Tick (tick)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // A load (IDLE exit or mode change) outranks a coincident tick.
    always_comb begin
        load = 1'b0;
        case (state_q)
            ST_IDLE: load = 1'b1;
            ST_RUN:  load = mode_change;
            default: load = 1'b1;
        endcase
    end

    always_comb begin
        init_pattern = '0;
        if (mode_is_walker(mode_in)) begin
            init_pattern = N_LED'(1);
        end else if (mode_in == MODE_STATUS) begin
            init_pattern = bus.Status;
        end
    end

    // Written as shift-or so a single-LED build rotates onto itself.
    assign rot_left = (pattern_q << 1) | (pattern_q >> (N_LED - 1));

    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        if (load) begin
            pattern_d = init_pattern;
            dir_d     = DIR_UP;
        end else if (mode_q == MODE_STATUS) begin
            pattern_d = bus.Status;
        end else if (tick) begin
            case (mode_q)
                MODE_CHASE: pattern_d = rot_left;
                MODE_BOUNCE: begin
                    if (N_LED == 1) begin
                        pattern_d = pattern_q;
                    end else if (dir_q == DIR_UP) begin
                        pattern_d = pattern_q << 1;
                        if (pattern_d[N_LED-1]) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        pattern_d = pattern_q >> 1;
                        if (pattern_d[0]) begin
                            dir_d = DIR_UP;
                        end
                    end
                end
                MODE_BLINK: pattern_d = ~pattern_q;
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mode_q     <= MODE_CHASE;
            pattern_q  <= '0;
            dir_q      <= DIR_UP;
            tick_out_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            dir_q      <= dir_d;
            tick_out_q <= tick_out_d;
        end
    end

    assign bus.Tick_Out = tick_out_q;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic                pwm_on;

    // The mask uses the next PWM count so LED lines up with the pattern register.
    assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    assign pwm_on    = (bus.Brightness == '1) || (pwm_cnt_d < bus.Brightness);

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_led_mask
        assign led_d[gi] = pattern_d[gi] & pwm_on;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign bus.LED = led_q;
`else
    assign bus.LED = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (N_LED=4, TICK_DIV=4).
module tb_led_pattern_gen;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    led_pattern_gen_if #(.N_LED(4), .PWM_BITS(4)) bus ();

    led_pattern_gen #(
        .N_LED    (4),
        .TICK_DIV (4),
        .PWM_BITS (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic [3:0] status;
        logic       freeze;
        logic [3:0] exp_led;
        logic       exp_tick;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic [1:0] m, logic [3:0] s, logic f,
                                logic [3:0] led, logic tk, int n);
        vec_t v;
        v.rst = r; v.mode = m; v.status = s; v.freeze = f;
        v.exp_led = led; v.exp_tick = tk;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(string name, logic [3:0] led_exp, logic tick_exp);
        total++;
        if (bus.LED !== led_exp || bus.Tick_Out !== tick_exp) begin
            bad++;
            $display("FAIL %s: got LED=%b Tick_Out=%b, want LED=%b Tick_Out=%b",
                     name, bus.LED, bus.Tick_Out, led_exp, tick_exp);
        end else begin
            $display("ok   %s: LED=%b Tick_Out=%b", name, bus.LED, bus.Tick_Out);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        bus.Freeze = 1'b0;
        step();
        step();
        chk("reset_state", 4'b0000, 1'b0);
        Rst = 1'b0;
    endtask

`ifdef LED_PWM_EN
    task automatic pwm_check(logic [3:0] b, int exp_on);
        int on_cnt = 0;
        int junk = 0;
        bus.Brightness = b;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.LED == 4'b1111) on_cnt++;
            else if (bus.LED != 4'b0000) junk++;
        end
        total++;
        if (on_cnt != exp_on || junk != 0) begin
            bad++;
            $display("FAIL pwm_duty b=%0d: got on=%0d partial=%0d, want on=%0d partial=0",
                     b, on_cnt, junk, exp_on);
        end else begin
            $display("ok   pwm_duty b=%0d: on=%0d of 16", b, on_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] bounce_exp [10];
        logic [3:0] prev;

        bus.Mode   = 2'b00;
        bus.Status = 4'b0000;
        bus.Freeze = 1'b0;
`ifdef LED_PWM_EN
        bus.Brightness = 4'hF;
`endif

        // rst, mode, status, freeze, expected LED, expected Tick_Out, repeat
        add(1, 2'b00, 4'h0, 0, 4'b0000, 0, 2);
        add(0, 2'b00, 4'h0, 0, 4'b0001, 0, 4);
        add(0, 2'b00, 4'h0, 0, 4'b0010, 1, 1);
        add(0, 2'b00, 4'h0, 0, 4'b0010, 0, 3);
        add(0, 2'b00, 4'h0, 0, 4'b0100, 1, 1);
        add(0, 2'b00, 4'h0, 0, 4'b0100, 0, 3);
        add(0, 2'b00, 4'h0, 0, 4'b1000, 1, 1);
        add(0, 2'b00, 4'h0, 0, 4'b1000, 0, 3);
        add(0, 2'b00, 4'h0, 0, 4'b0001, 1, 1);
        add(0, 2'b11, 4'hA, 0, 4'b1010, 0, 1);
        add(0, 2'b11, 4'h5, 0, 4'b0101, 0, 1);
        add(0, 2'b11, 4'h6, 1, 4'b0110, 0, 1);
        add(0, 2'b00, 4'h6, 0, 4'b0001, 0, 4);
        add(0, 2'b00, 4'h6, 0, 4'b0010, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            Rst        = vecs[i].rst;
            bus.Mode   = vecs[i].mode;
            bus.Status = vecs[i].status;
            bus.Freeze = vecs[i].freeze;
            step();
            chk($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_tick);
        end

        // BOUNCE sweep, then reset while moving down
        bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                       4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        bus.Mode = 2'b01;
        do_reset();
        step();
        chk("bounce_init", 4'b0001, 1'b0);
        prev = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            repeat (3) step();
            chk($sformatf("bounce_hold%0d", i), prev, 1'b0);
            step();
            chk($sformatf("bounce_step%0d", i), bounce_exp[i], 1'b1);
            prev = bounce_exp[i];
        end
        step();
        step();
        Rst = 1'b1;
        step();
        chk("rst_mid_bounce", 4'b0000, 1'b0);
        Rst = 1'b0;
        step();
        chk("rst_idle_exit", 4'b0001, 1'b0);
        repeat (3) step();
        step();
        chk("rst_dir_up", 4'b0010, 1'b1);

        // CHASE -> BLINK on the tick cycle: the chase step is dropped
        bus.Mode = 2'b00;
        do_reset();
        step();
        repeat (3) step();
        chk("tick_cycle_led", 4'b0001, 1'b0);
        bus.Mode = 2'b10;
        step();
        chk("mode_chg_on_tick", 4'b0000, 1'b0);
        repeat (3) step();
        chk("blink_hold", 4'b0000, 1'b0);
        step();
        chk("blink_on", 4'b1111, 1'b1);
        repeat (4) step();
        chk("blink_off", 4'b0000, 1'b1);

        // Freeze in CHASE at 0100
        bus.Mode = 2'b00;
        do_reset();
        step();
        repeat (8) step();
        chk("pre_freeze", 4'b0100, 1'b1);
        bus.Freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("freeze_hold%0d", i), 4'b0100, 1'b0);
        end
        bus.Freeze = 1'b0;
        repeat (3) step();
        chk("thaw_hold", 4'b0100, 1'b0);
        step();
        chk("thaw_step", 4'b1000, 1'b1);

        // Mode change still lands while frozen
        bus.Freeze = 1'b1;
        bus.Mode   = 2'b10;
        step();
        chk("freeze_mode_chg", 4'b0000, 1'b0);
        repeat (6) step();
        chk("freeze_blink_hold", 4'b0000, 1'b0);
        bus.Freeze = 1'b0;
        repeat (4) step();
        chk("freeze_blink_resume", 4'b1111, 1'b1);

`ifdef LED_PWM_EN
        bus.Mode   = 2'b11;
        bus.Status = 4'b1111;
        do_reset();
        step();
        pwm_check(4'd4, 4);
        pwm_check(4'd15, 16);
        pwm_check(4'd0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
